// File: rtl/sd_bus_arbiter.sv
// SD-card SPI bus owner: hands the bus to the init sequencer, then grants queued
// sector read/write jobs one at a time with fair alternation and a per-job watchdog.
module sd_bus_arbiter #(
    parameter logic [31:0] TIMEOUT_MAX = 32'd5_000_000,
    parameter int          ADDR_W      = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_end,
    input  logic              init_cs_n,
    input  logic              init_mosi,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_busy,
    input  logic              rd_cs_n,
    input  logic              rd_mosi,
    input  logic              wr_busy,
    input  logic              wr_cs_n,
    input  logic              wr_mosi,
    output logic              rd_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] sec_addr,
    output logic              rd_done,
    output logic              wr_done,
    output logic              timeout_err,
    output logic              ready,
    output logic              cs_n,
    output logic              mosi
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RD_START = 3'd2,
        ST_RD_RUN   = 3'd3,
        ST_WR_START = 3'd4,
        ST_WR_RUN   = 3'd5
    } state_t;

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    state_t            state_reg, state_next;
    logic              rd_pend_reg, wr_pend_reg;
    logic [ADDR_W-1:0] rd_addr_reg, wr_addr_reg, sec_addr_reg;
    logic              last_grant_reg, last_grant_next;
    logic              seen_busy_reg, seen_busy_next;
    logic [31:0]       count_reg, count_next;
    logic              rd_done_reg, rd_done_next;
    logic              wr_done_reg, wr_done_next;
    logic              timeout_reg, timeout_next;
    logic              rd_clr, wr_clr, load_rd, load_wr;

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        seen_busy_next  = seen_busy_reg;
        count_next      = count_reg;
        rd_done_next    = 1'b0;
        wr_done_next    = 1'b0;
        timeout_next    = 1'b0;
        rd_clr          = 1'b0;
        wr_clr          = 1'b0;
        load_rd         = 1'b0;
        load_wr         = 1'b0;
        case (state_reg)
            ST_INIT: begin
                if (init_end) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                // On a tie the side that did not go last is served.
                if (rd_pend_reg && (!wr_pend_reg || last_grant_reg == GRANT_WR)) begin
                    load_rd    = 1'b1;
                    state_next = ST_RD_START;
                end else if (wr_pend_reg) begin
                    load_wr    = 1'b1;
                    state_next = ST_WR_START;
                end
            end
            ST_RD_START: begin
                seen_busy_next = 1'b0;
                count_next     = '0;
                state_next     = ST_RD_RUN;
            end
            ST_RD_RUN: begin
                seen_busy_next = seen_busy_reg | rd_busy;
                count_next     = count_reg + 32'd1;
                if (seen_busy_reg && !rd_busy) begin
                    rd_done_next    = 1'b1;
                    rd_clr          = 1'b1;
                    last_grant_next = GRANT_RD;
                    state_next      = ST_IDLE;
                end else if (count_reg == TIMEOUT_MAX - 32'd1) begin
                    timeout_next    = 1'b1;
                    rd_clr          = 1'b1;
                    last_grant_next = GRANT_RD;
                    state_next      = ST_IDLE;
                end
            end
            ST_WR_START: begin
                seen_busy_next = 1'b0;
                count_next     = '0;
                state_next     = ST_WR_RUN;
            end
            ST_WR_RUN: begin
                seen_busy_next = seen_busy_reg | wr_busy;
                count_next     = count_reg + 32'd1;
                if (seen_busy_reg && !wr_busy) begin
                    wr_done_next    = 1'b1;
                    wr_clr          = 1'b1;
                    last_grant_next = GRANT_WR;
                    state_next      = ST_IDLE;
                end else if (count_reg == TIMEOUT_MAX - 32'd1) begin
                    timeout_next    = 1'b1;
                    wr_clr          = 1'b1;
                    last_grant_next = GRANT_WR;
                    state_next      = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg      <= ST_INIT;
            rd_pend_reg    <= 1'b0;
            wr_pend_reg    <= 1'b0;
            rd_addr_reg    <= '0;
            wr_addr_reg    <= '0;
            sec_addr_reg   <= '0;
            last_grant_reg <= GRANT_WR;
            seen_busy_reg  <= 1'b0;
            count_reg      <= '0;
            rd_done_reg    <= 1'b0;
            wr_done_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            seen_busy_reg  <= seen_busy_next;
            count_reg      <= count_next;
            rd_done_reg    <= rd_done_next;
            wr_done_reg    <= wr_done_next;
            timeout_reg    <= timeout_next;
            // A new request arriving as the old job retires re-arms the flag.
            if (rd_req && (!rd_pend_reg || rd_clr)) begin
                rd_pend_reg <= 1'b1;
                rd_addr_reg <= rd_addr;
            end else if (rd_clr) begin
                rd_pend_reg <= 1'b0;
            end
            if (wr_req && (!wr_pend_reg || wr_clr)) begin
                wr_pend_reg <= 1'b1;
                wr_addr_reg <= wr_addr;
            end else if (wr_clr) begin
                wr_pend_reg <= 1'b0;
            end
            if (load_rd) begin
                sec_addr_reg <= rd_addr_reg;
            end else if (load_wr) begin
                sec_addr_reg <= wr_addr_reg;
            end
        end
    end

    always_comb begin
        cs_n = 1'b1;
        mosi = 1'b1;
        case (state_reg)
            ST_INIT: begin
                cs_n = init_cs_n;
                mosi = init_mosi;
            end
            ST_RD_START, ST_RD_RUN: begin
                cs_n = rd_cs_n;
                mosi = rd_mosi;
            end
            ST_WR_START, ST_WR_RUN: begin
                cs_n = wr_cs_n;
                mosi = wr_mosi;
            end
            default: begin
                cs_n = 1'b1;
                mosi = 1'b1;
            end
        endcase
    end

    assign rd_en       = (state_reg == ST_RD_START);
    assign wr_en       = (state_reg == ST_WR_START);
    assign ready       = (state_reg == ST_IDLE) && !rd_pend_reg && !wr_pend_reg;
    assign sec_addr    = sec_addr_reg;
    assign rd_done     = rd_done_reg;
    assign wr_done     = wr_done_reg;
    assign timeout_err = timeout_reg;

endmodule
